// File: rtl/access_session_ctrl.sv
// access_session_ctrl: sequences one access-control session covering login,
// permission-checked function launch, completion wait, failed-login lockout
// and idle logout. Every output is taken straight from a flop.
module access_session_ctrl #(
    parameter int MAX_FAIL       = 3,
    parameter int LOCK_CYCLES    = 16,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       login_req,
    input  logic [2:0] auth_code,
    input  logic       func_req,
    input  logic [2:0] func_code,
    input  logic       logout,
    input  logic       func_done,
    output logic       session_active,
    output logic       busy,
    output logic       locked,
    output logic       grant,
    output logic       deny,
    output logic       func_start,
    output logic [2:0] func_sel,
    output logic [1:0] fail_count
);

    localparam int IW = $clog2(TIMEOUT_CYCLES);
    localparam int LW = $clog2(LOCK_CYCLES);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_SESSION = 2'd1;
    localparam logic [1:0] S_BUSY    = 2'd2;
    localparam logic [1:0] S_LOCKED  = 2'd3;

    // Function-permission bitmap for each authentication code; zero means the code is invalid.
    function automatic logic [7:0] perm_mask(input logic [2:0] code);
        logic [7:0] m;
        case (code)
            3'd1:    m = 8'h5A;
            3'd3:    m = 8'h5E;
            3'd5:    m = 8'hFE;
            3'd6:    m = 8'h42;
            default: m = 8'h00;
        endcase
        return m;
    endfunction

    logic [1:0]    r_state;
    logic [2:0]    r_auth;
    logic [1:0]    r_fail_count;
    logic [2:0]    r_func_sel;
    logic [IW-1:0] r_idle_cnt;
    logic [LW-1:0] r_lock_cnt;
    logic          r_logout_pend;
    logic          r_session_active;
    logic          r_busy;
    logic          r_locked;
    logic          r_grant;
    logic          r_deny;
    logic          r_func_start;

    logic [1:0]    w_state_n;
    logic [2:0]    w_auth_n;
    logic [1:0]    w_fail_n;
    logic [2:0]    w_sel_n;
    logic [IW-1:0] w_idle_n;
    logic [LW-1:0] w_lock_n;
    logic          w_pend_n;
    logic          w_grant_n;
    logic          w_deny_n;
    logic          w_start_n;
    logic [7:0]    w_mask;
    logic [1:0]    w_fail_inc;

    assign w_mask     = perm_mask(r_auth);
    assign w_fail_inc = r_fail_count + 2'd1;

    // Next-state and next-output decode for the session sequencer.
    always_comb begin
        w_state_n = r_state;
        w_auth_n  = r_auth;
        w_fail_n  = r_fail_count;
        w_sel_n   = r_func_sel;
        w_idle_n  = r_idle_cnt;
        w_lock_n  = r_lock_cnt;
        w_pend_n  = r_logout_pend;
        w_grant_n = 1'b0;
        w_deny_n  = 1'b0;
        w_start_n = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_idle_n = '0;
                w_lock_n = '0;
                w_pend_n = 1'b0;
                // func_req and logout are meaningless without a session.
                if (login_req) begin
                    if (perm_mask(auth_code) != 8'h00) begin
                        w_grant_n = 1'b1;
                        w_auth_n  = auth_code;
                        w_fail_n  = 2'd0;
                        w_state_n = S_SESSION;
                    end else begin
                        w_deny_n = 1'b1;
                        w_fail_n = w_fail_inc;
                        if (w_fail_inc == 2'(MAX_FAIL)) begin
                            w_state_n = S_LOCKED;
                        end else begin
                            w_state_n = S_IDLE;
                        end
                    end
                end else begin
                    w_state_n = S_IDLE;
                end
            end
            S_SESSION: begin
                if (logout) begin
                    w_state_n = S_IDLE;
                    w_auth_n  = 3'd0;
                    w_idle_n  = '0;
                end else if (func_req) begin
                    w_idle_n = '0;
                    if (w_mask[func_code]) begin
                        w_grant_n = 1'b1;
                        w_start_n = 1'b1;
                        w_sel_n   = func_code;
                        w_pend_n  = 1'b0;
                        w_state_n = S_BUSY;
                    end else begin
                        w_deny_n = 1'b1;
                    end
                end else if (login_req) begin
                    // A second login inside a session is not processed but still counts as activity.
                    w_idle_n = '0;
                end else if (r_idle_cnt == IW'(TIMEOUT_CYCLES - 1)) begin
                    w_state_n = S_IDLE;
                    w_auth_n  = 3'd0;
                    w_idle_n  = '0;
                end else begin
                    w_idle_n = r_idle_cnt + IW'(1);
                end
            end
            S_BUSY: begin
                if (func_req) begin
                    w_deny_n = 1'b1;
                end else begin
                    w_deny_n = 1'b0;
                end
                if (func_done) begin
                    w_pend_n = 1'b0;
                    w_idle_n = '0;
                    if (r_logout_pend || logout) begin
                        w_state_n = S_IDLE;
                        w_auth_n  = 3'd0;
                    end else begin
                        w_state_n = S_SESSION;
                    end
                end else if (logout) begin
                    w_pend_n = 1'b1;
                end else begin
                    w_pend_n = r_logout_pend;
                end
            end
            S_LOCKED: begin
                if (login_req) begin
                    w_deny_n = 1'b1;
                end else begin
                    w_deny_n = 1'b0;
                end
                if (r_lock_cnt == LW'(LOCK_CYCLES - 1)) begin
                    w_state_n = S_IDLE;
                    w_fail_n  = 2'd0;
                    w_lock_n  = '0;
                end else begin
                    w_lock_n = r_lock_cnt + LW'(1);
                end
            end
            default: begin
                w_state_n = S_IDLE;
            end
        endcase
    end

    // State, context and registered-output update; reset aborts everything silently.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state          <= S_IDLE;
            r_auth           <= 3'd0;
            r_fail_count     <= 2'd0;
            r_func_sel       <= 3'd0;
            r_idle_cnt       <= '0;
            r_lock_cnt       <= '0;
            r_logout_pend    <= 1'b0;
            r_session_active <= 1'b0;
            r_busy           <= 1'b0;
            r_locked         <= 1'b0;
            r_grant          <= 1'b0;
            r_deny           <= 1'b0;
            r_func_start     <= 1'b0;
        end else begin
            r_state          <= w_state_n;
            r_auth           <= w_auth_n;
            r_fail_count     <= w_fail_n;
            r_func_sel       <= w_sel_n;
            r_idle_cnt       <= w_idle_n;
            r_lock_cnt       <= w_lock_n;
            r_logout_pend    <= w_pend_n;
            r_session_active <= (w_state_n == S_SESSION) || (w_state_n == S_BUSY);
            r_busy           <= (w_state_n == S_BUSY);
            r_locked         <= (w_state_n == S_LOCKED);
            r_grant          <= w_grant_n;
            r_deny           <= w_deny_n;
            r_func_start     <= w_start_n;
        end
    end

    assign session_active = r_session_active;
    assign busy           = r_busy;
    assign locked         = r_locked;
    assign grant          = r_grant;
    assign deny           = r_deny;
    assign func_start     = r_func_start;
    assign func_sel       = r_func_sel;
    assign fail_count     = r_fail_count;

endmodule

// File: tb/tb_access_session_ctrl.sv
// Scoreboard bench for access_session_ctrl: the stimulus process feeds a
// behavioural session model and queues the expected outputs; a monitor
// pops one entry per cycle and compares it with the DUT.
module tb_access_session_ctrl;

    localparam int MAX_FAIL       = 3;
    localparam int LOCK_CYCLES    = 16;
    localparam int TIMEOUT_CYCLES = 64;

    logic       clk = 1'b0;
    logic       reset, login_req, func_req, logout, func_done;
    logic [2:0] auth_code, func_code;
    logic       session_active, busy, locked, grant, deny, func_start;
    logic [2:0] func_sel;
    logic [1:0] fail_count;

    access_session_ctrl #(
        .MAX_FAIL(MAX_FAIL), .LOCK_CYCLES(LOCK_CYCLES), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk(clk), .reset(reset), .login_req(login_req), .auth_code(auth_code),
        .func_req(func_req), .func_code(func_code), .logout(logout), .func_done(func_done),
        .session_active(session_active), .busy(busy), .locked(locked), .grant(grant),
        .deny(deny), .func_start(func_start), .func_sel(func_sel), .fail_count(fail_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       sa, bs, lk, gr, dn, fs;
        logic [2:0] sel;
        logic [1:0] fc;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Behavioural model: booleans for "logged in", "function running", "locked out".
    bit   m_in_session, m_running, m_lockout, m_pend;
    int   m_auth, m_fails, m_idle, m_lock_left, m_sel;
    int   perm [8];

    function automatic bit allowed(input int a, input int f);
        return ((perm[a] >> f) & 1) == 1;
    endfunction

    task automatic model_step(input bit rst, input bit lg, input int ac, input bit fr,
                              input int fc, input bit lo, input bit dn);
        exp_t e;
        bit g = 0, d = 0, st = 0;
        if (rst) begin
            m_in_session = 0; m_running = 0; m_lockout = 0; m_pend = 0;
            m_auth = 0; m_fails = 0; m_idle = 0; m_lock_left = 0; m_sel = 0;
        end else if (m_lockout) begin
            if (lg) d = 1;
            m_lock_left--;
            if (m_lock_left == 0) begin m_lockout = 0; m_fails = 0; end
        end else if (m_running) begin
            if (fr) d = 1;
            if (dn) begin
                m_running = 0;
                if (m_pend || lo) begin m_in_session = 0; m_auth = 0; end
                m_idle = 0; m_pend = 0;
            end else if (lo) m_pend = 1;
        end else if (m_in_session) begin
            if (lo) begin m_in_session = 0; m_auth = 0; m_idle = 0; end
            else if (fr) begin
                m_idle = 0;
                if (allowed(m_auth, fc)) begin g = 1; st = 1; m_sel = fc; m_running = 1; m_pend = 0; end
                else d = 1;
            end else if (lg) m_idle = 0;
            else begin
                m_idle++;
                if (m_idle == TIMEOUT_CYCLES) begin m_in_session = 0; m_auth = 0; m_idle = 0; end
            end
        end else if (lg) begin
            if (perm[ac] != 0) begin g = 1; m_auth = ac; m_fails = 0; m_in_session = 1; m_idle = 0; end
            else begin
                d = 1; m_fails++;
                if (m_fails == MAX_FAIL) begin m_lockout = 1; m_lock_left = LOCK_CYCLES; end
            end
        end
        e.sa = m_in_session; e.bs = m_running; e.lk = m_lockout;
        e.gr = g; e.dn = d; e.fs = st;
        e.sel = 3'(m_sel); e.fc = 2'(m_fails);
        sb_q.push_back(e);
    endtask

    task automatic cyc(input bit rst, input bit lg, input int ac, input bit fr,
                       input int fc, input bit lo, input bit dn);
        @(negedge clk);
        reset = rst; login_req = lg; auth_code = 3'(ac); func_req = fr;
        func_code = 3'(fc); logout = lo; func_done = dn;
        model_step(rst, lg, ac, fr, fc, lo, dn);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0);
    endtask
    task automatic do_login(input int a);  cyc(0, 1, a, 0, 0, 0, 0); endtask
    task automatic do_func(input int f);   cyc(0, 0, 0, 1, f, 0, 0); endtask
    task automatic do_logout();            cyc(0, 0, 0, 0, 0, 1, 0); endtask
    task automatic do_done();              cyc(0, 0, 0, 0, 0, 0, 1); endtask
    task automatic do_reset();             cyc(1, 0, 0, 0, 0, 0, 0); endtask

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp_v, $time);
        end
    endtask

    // Monitor: one expected record per clock, compared just after the active edge.
    exp_t me;
    always @(posedge clk) begin
        #1;
        if (sb_q.size() > 0) begin
            me = sb_q.pop_front();
            chk("session_active", {7'd0, session_active}, {7'd0, me.sa});
            chk("busy",           {7'd0, busy},           {7'd0, me.bs});
            chk("locked",         {7'd0, locked},         {7'd0, me.lk});
            chk("grant",          {7'd0, grant},          {7'd0, me.gr});
            chk("deny",           {7'd0, deny},           {7'd0, me.dn});
            chk("func_start",     {7'd0, func_start},     {7'd0, me.fs});
            chk("func_sel",       {5'd0, func_sel},       {5'd0, me.sel});
            chk("fail_count",     {6'd0, fail_count},     {6'd0, me.fc});
        end
    end

    initial begin
        perm[0] = 0;
        perm[1] = (1 << 1) | (1 << 3) | (1 << 4) | (1 << 6);
        perm[2] = 0;
        perm[3] = (1 << 1) | (1 << 2) | (1 << 3) | (1 << 4) | (1 << 6);
        perm[4] = 0;
        perm[5] = 'hFE;
        perm[6] = (1 << 1) | (1 << 6);
        perm[7] = 0;
        reset = 1'b1; login_req = 1'b0; auth_code = 3'd0; func_req = 1'b0;
        func_code = 3'd0; logout = 1'b0; func_done = 1'b0;

        // Basic login, launch, completion.
        do_reset(); do_reset(); idle(1);
        do_login(5); do_func(7); idle(2); do_func(1); do_done(); idle(2);
        // Permission check in a restricted session.
        do_logout(); do_login(6); do_func(3); do_func(6); do_done();
        do_logout(); do_login(6); do_func(0); do_logout();
        // Lockout and recovery.
        do_login(2); do_login(2); do_login(2); do_login(5);
        idle(LOCK_CYCLES); do_login(5); do_logout();
        // Idle timeout, then a stray request.
        do_login(1); idle(TIMEOUT_CYCLES + 2); do_func(3); idle(1);
        // Pending logout while busy.
        do_login(3); do_func(2); idle(2); do_logout(); idle(2); do_done(); idle(2);
        // Logout together with completion; simultaneous login and func_req in IDLE.
        cyc(0, 1, 3, 1, 2, 0, 0); do_func(2); cyc(0, 0, 0, 0, 0, 1, 1); idle(1);
        // Reset while busy.
        do_login(5); do_func(7); idle(2); do_reset(); do_done(); idle(3);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 299) == 0),
                ($urandom_range(0, 5) == 0), int'($urandom_range(0, 7)),
                ($urandom_range(0, 3) == 0), int'($urandom_range(0, 7)),
                ($urandom_range(0, 19) == 0), ($urandom_range(0, 3) == 0));
        end
        idle(4);
        @(negedge clk);
        @(negedge clk);
        chk("scoreboard_drained", 8'(sb_q.size()), 8'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/access_session_ctrl.md
Name: access_session_ctrl

Overview:
- Sequences one user session on the access-control datapath: login with a 3-bit authentication code, function requests with a 3-bit function code, permission check, function launch, and completion wait.
- Counts failed logins, locks out after repeated failures, and closes idle sessions.
- Sits between the keypad/front-end request logic and the function execution units.

Parameters:
- MAX_FAIL, 3, consecutive failed logins that trigger lockout (1..3).
- LOCK_CYCLES, 16, clock cycles spent in LOCKED before returning to IDLE (>=2).
- TIMEOUT_CYCLES, 64, consecutive idle cycles in SESSION before automatic logout (>=2).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- login_req  input  1  1-cycle login request; auth_code sampled with it.
- auth_code  input  3  authentication code, bit 2 MSB.
- func_req  input  1  1-cycle function request; func_code sampled with it.
- func_code  input  3  function code, bit 2 MSB.
- logout  input  1  1-cycle logout request.
- func_done  input  1  level/pulse from the execution unit: function finished.
- session_active  output  1  high in SESSION and BUSY.
- busy  output  1  high in BUSY.
- locked  output  1  high in LOCKED.
- grant  output  1  1-cycle pulse: request accepted (login or function).
- deny  output  1  1-cycle pulse: request refused (login or function).
- func_start  output  1  1-cycle pulse launching the selected function.
- func_sel  output  3  latched function code of the running/last granted function.
- fail_count  output  2  current consecutive failed-login count.

Behaviour:
- Permission mask per auth code (bit n = function n allowed): 0->0x00, 1->0x5A (1,3,4,6), 2->0x00, 3->0x5E (1,2,3,4,6), 4->0x00, 5->0xFE (1..7), 6->0x42 (1,6), 7->0x00. Function 0 is never allowed. An auth code is valid iff its mask is non-zero.
- All outputs are registered. Each response appears on the cycle after the request is sampled.
- Reset: state IDLE; all outputs 0, including func_sel=0 and fail_count=0; all counters 0. Reset mid-session or mid-function aborts with no pulse.
- IDLE:
  - login_req with a valid code: grant=1, latch auth_code, fail_count cleared, go to SESSION.
  - login_req with an invalid code: deny=1, fail_count+1. If the new count equals MAX_FAIL, go to LOCKED.
  - func_req and logout are ignored, with no pulse.
- SESSION:
  - Priority is logout > func_req > login_req (login_req is ignored here).
  - logout: go to IDLE, no pulse, auth code cleared.
  - func_req permitted by the latched auth mask: grant=1 and func_start=1 in the same cycle, func_sel<=func_code, go to BUSY.
  - func_req not permitted: deny=1, stay in SESSION. This does not change fail_count.
  - Idle counter increments on every SESSION cycle with no login_req, func_req or logout. Any of these resets it to 0. On reaching TIMEOUT_CYCLES, go to IDLE, no pulse.
- BUSY:
  - Wait for func_done, then go to SESSION with the idle counter at 0.
  - func_req in BUSY: deny=1, with no effect on func_sel.
  - logout in BUSY is captured in a pending flag. On func_done, the pending flag sends the block to IDLE instead of SESSION. func_done and logout in the same cycle also go to IDLE.
  - No timeout in BUSY.
  - func_done outside BUSY is ignored.
- LOCKED:
  - Counts LOCK_CYCLES cycles. login_req in LOCKED gives deny=1 and does not extend the lock.
  - On expiry: fail_count<=0, go to IDLE.
- grant and deny are never high in the same cycle. func_start is only ever high together with grant.
- Simultaneous login_req and func_req in IDLE: the login is processed and func_req is dropped.

Test Plan:
- Reset, then login auth=5 -> grant next cycle, session_active=1. func_req func=7 -> grant+func_start, func_sel=7, busy=1. func_done -> busy=0, session_active=1.
- Login auth=6; func_req func=3 -> deny, state stays SESSION; func_req func=6 -> grant, func_sel=6; func_req func=0 in a fresh session -> deny.
- Three logins with auth=2 -> deny each time, fail_count 1,2,3, locked=1. login auth=5 during lock -> deny, no grant. After 16 cycles -> locked=0, fail_count=0; login auth=5 -> grant.
- Login auth=1, then no activity for 64 cycles -> session_active=0. A func_req afterwards -> no pulse.
- Login auth=3, func_req func=2 (BUSY), logout mid-run -> still busy; func_done -> state IDLE, session_active=0.
- Reset asserted while in BUSY -> next cycle all outputs 0, fail_count=0, and func_done is ignored afterwards.
